// File: rtl/tlb_arb_pkg.sv
// Shared types and widths for the TLB search arbiter.
// FSM states, owner codes and the captured search result.
package tlb_arb_pkg;

  localparam int VPN2_W = 19;
  localparam int PFN_W  = 20;
  localparam int IDX_W  = 4;
  localparam int ASID_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_INST  = 2'd0,
    OWN_DATA  = 2'd1,
    OWN_PROBE = 2'd2
  } owner_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] index;
    logic [PFN_W-1:0] pfn;
    logic [2:0]       c;
    logic             d;
    logic             v;
  } tlb_res_t;

endpackage

// File: rtl/tlb_search_arbiter_if.sv
// TLB search port: key out to the TLB array,
// combinational match result back.
interface tlb_search_arbiter_if;
  import tlb_arb_pkg::*;

  logic [VPN2_W-1:0] s_vpn2;
  logic              s_odd_page;
  logic [ASID_W-1:0] s_asid;
  logic              s_found;
  logic [IDX_W-1:0]  s_index;
  logic [PFN_W-1:0]  s_pfn;
  logic [2:0]        s_c;
  logic              s_d;
  logic              s_v;

  modport master (
    output s_vpn2, s_odd_page, s_asid,
    input  s_found, s_index, s_pfn,
    input  s_c, s_d, s_v
  );

  modport slave (
    input  s_vpn2, s_odd_page, s_asid,
    output s_found, s_index, s_pfn,
    output s_c, s_d, s_v
  );

endinterface

// File: rtl/tlb_rr_pick.sv
// Requester selection: probe always wins,
// inst/data alternate by the round-robin bit.
module tlb_rr_pick
  import tlb_arb_pkg::*;
(
  input  logic   probe_req,
  input  logic   inst_req,
  input  logic   data_req,
  input  logic   rr_data,
  output logic   gnt,
  output owner_e gnt_owner
);

  logic pick_i;
  logic pick_d;

  assign pick_i = ~probe_req & inst_req
                & (~data_req | ~rr_data);
  assign pick_d = ~probe_req & data_req
                & (~inst_req | rr_data);

  // One-hot select of the winning requester
  always_comb begin
    gnt       = probe_req | inst_req | data_req;
    gnt_owner = OWN_INST;
    unique case (1'b1)
      probe_req: gnt_owner = OWN_PROBE;
      pick_i:    gnt_owner = OWN_INST;
      pick_d:    gnt_owner = OWN_DATA;
      default:   gnt_owner = OWN_INST;
    endcase
  end

endmodule

// File: rtl/tlb_search_arbiter.sv
// Shares one TLB search port between fetch, load/store
// and tlbp; one lookup in flight, result held until taken.
module tlb_search_arbiter
  import tlb_arb_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [31:0]       inst_va,
  output logic              inst_ack,
  output logic              inst_rsp_valid,
  input  logic              inst_rsp_ready,
  input  logic              data_req,
  input  logic [31:0]       data_va,
  output logic              data_ack,
  output logic              data_rsp_valid,
  input  logic              data_rsp_ready,
  input  logic              probe_req,
  output logic              probe_done,
  input  logic [31:0]       cp0_entryhi,
  input  logic              tlb_write,
  tlb_search_arbiter_if.master tlb,
  output logic              rsp_found,
  output logic [IDX_W-1:0]  rsp_index,
  output logic [PFN_W-1:0]  rsp_pfn,
  output logic [2:0]        rsp_c,
  output logic              rsp_d,
  output logic              rsp_v
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [VPN2_W-1:0] vpn2_q, vpn2_d;
  logic              odd_q, odd_d;
  logic [ASID_W-1:0] asid_q, asid_d;
  logic              rr_q, rr_d;
  tlb_res_t          res_q, res_d;

  logic              gnt;
  owner_e            gnt_owner;

  logic unused_bits;
  assign unused_bits = ^{inst_va[11:0],
                         data_va[11:0],
                         cp0_entryhi[12:8]};

  tlb_rr_pick u_pick (
    .probe_req (probe_req),
    .inst_req  (inst_req),
    .data_req  (data_req),
    .rr_data   (rr_q),
    .gnt       (gnt),
    .gnt_owner (gnt_owner)
  );

  // State, search key, result and rr registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_INST;
      vpn2_q  <= '0;
      odd_q   <= 1'b0;
      asid_q  <= '0;
      rr_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      vpn2_q  <= vpn2_d;
      odd_q   <= odd_d;
      asid_q  <= asid_d;
      rr_q    <= rr_d;
      res_q   <= res_d;
    end
  end

  // Grant, search, respond; a TLB write restarts the search
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    vpn2_d         = vpn2_q;
    odd_d          = odd_q;
    asid_d         = asid_q;
    rr_d           = rr_q;
    res_d          = res_q;
    inst_ack       = 1'b0;
    data_ack       = 1'b0;
    inst_rsp_valid = 1'b0;
    data_rsp_valid = 1'b0;
    probe_done     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt) begin
          owner_d = gnt_owner;
          asid_d  = cp0_entryhi[7:0];
          state_d = ST_SEARCH;
          unique case (gnt_owner)
            OWN_INST: begin
              inst_ack = 1'b1;
              vpn2_d   = inst_va[31:13];
              odd_d    = inst_va[12];
            end
            OWN_DATA: begin
              data_ack = 1'b1;
              vpn2_d   = data_va[31:13];
              odd_d    = data_va[12];
            end
            default: begin
              vpn2_d = cp0_entryhi[31:13];
              odd_d  = 1'b0;
            end
          endcase
        end
      end
      ST_SEARCH: begin
        if (!tlb_write) begin
          res_d.found = tlb.s_found;
          res_d.index = tlb.s_index;
          res_d.pfn   = tlb.s_pfn;
          res_d.c     = tlb.s_c;
          res_d.d     = tlb.s_d;
          res_d.v     = tlb.s_v;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        unique case (owner_q)
          OWN_INST: begin
            inst_rsp_valid = 1'b1;
            if (inst_rsp_ready) begin
              state_d = ST_IDLE;
              rr_d    = 1'b1;
            end else if (tlb_write) begin
              state_d = ST_SEARCH;
            end
          end
          OWN_DATA: begin
            data_rsp_valid = 1'b1;
            if (data_rsp_ready) begin
              state_d = ST_IDLE;
              rr_d    = 1'b0;
            end else if (tlb_write) begin
              state_d = ST_SEARCH;
            end
          end
          OWN_PROBE: begin
            probe_done = 1'b1;
            state_d    = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tlb.s_vpn2     = vpn2_q;
  assign tlb.s_odd_page = odd_q;
  assign tlb.s_asid     = asid_q;

  assign rsp_found = res_q.found;
  assign rsp_index = res_q.index;
  assign rsp_pfn   = res_q.pfn;
  assign rsp_c     = res_q.c;
  assign rsp_d     = res_q.d;
  assign rsp_v     = res_q.v;

endmodule

// File: tb/tb_tlb_search_arbiter.sv
// Bench for tlb_search_arbiter: directed scenarios plus
// random traffic against a transaction-level scoreboard.
module tb_tlb_search_arbiter;
  import tlb_arb_pkg::*;

  typedef struct packed {
    logic        found;
    logic [3:0]  index;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } tres_t;

  typedef struct {
    owner_e      own;
    logic [18:0] vpn2;
    logic        odd;
    logic [7:0]  asid;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_va = '0;
  logic        inst_ack;
  logic        inst_rsp_valid;
  logic        inst_rsp_ready = 1'b1;
  logic        data_req = 1'b0;
  logic [31:0] data_va = '0;
  logic        data_ack;
  logic        data_rsp_valid;
  logic        data_rsp_ready = 1'b1;
  logic        probe_req = 1'b0;
  logic        probe_done;
  logic [31:0] cp0_entryhi = '0;
  logic        tlb_write = 1'b0;
  logic        rsp_found;
  logic [3:0]  rsp_index;
  logic [19:0] rsp_pfn;
  logic [2:0]  rsp_c;
  logic        rsp_d;
  logic        rsp_v;
  logic [29:0] rsp_vec;

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned gen = 0;
  bit ov_en = 1'b0;
  bit hold = 1'b0;
  int cyc = 0;

  exp_t sb_q[$];
  bit   mon_busy = 1'b0;
  bit   fav_data = 1'b0;
  bit   wr_seen = 1'b0;
  int   wait_cyc = 0;

  logic        smp_iack, smp_dack, smp_pd;
  logic        smp_iv, smp_dv;
  logic [18:0] smp_vpn2;
  logic        smp_odd;
  logic [7:0]  smp_asid;
  logic [29:0] smp_rsp;

  tres_t tres;

  always #5 clk = ~clk;

  tlb_search_arbiter_if tif ();

  tlb_search_arbiter u_dut (
    .clk            (clk),
    .resetn         (resetn),
    .inst_req       (inst_req),
    .inst_va        (inst_va),
    .inst_ack       (inst_ack),
    .inst_rsp_valid (inst_rsp_valid),
    .inst_rsp_ready (inst_rsp_ready),
    .data_req       (data_req),
    .data_va        (data_va),
    .data_ack       (data_ack),
    .data_rsp_valid (data_rsp_valid),
    .data_rsp_ready (data_rsp_ready),
    .probe_req      (probe_req),
    .probe_done     (probe_done),
    .cp0_entryhi    (cp0_entryhi),
    .tlb_write      (tlb_write),
    .tlb            (tif),
    .rsp_found      (rsp_found),
    .rsp_index      (rsp_index),
    .rsp_pfn        (rsp_pfn),
    .rsp_c          (rsp_c),
    .rsp_d          (rsp_d),
    .rsp_v          (rsp_v)
  );

  assign rsp_vec = {rsp_found, rsp_index, rsp_pfn,
                    rsp_c, rsp_d, rsp_v};

  // TLB contents: a hash of the key and a generation
  // number that advances on every committed write.
  function automatic tres_t lookup(
    input logic [18:0] vpn2, input logic odd,
    input logic [7:0] asid, input int unsigned g,
    input bit ov);
    logic [31:0] h;
    tres_t r;
    h = ({13'd0, vpn2} * 32'h9E37_79B1)
      ^ ({24'd0, asid} << 5) ^ {31'd0, odd}
      ^ (g * 32'h85EB_CA6B);
    r.found = h[3] | h[17];
    r.index = h[7:4];
    r.pfn   = h[27:8];
    r.c     = h[30:28];
    r.d     = h[31];
    r.v     = h[2] ^ odd;
    if (ov && vpn2 == 19'h00201 && odd
        && asid == 8'h12) begin
      r.found = 1'b1;
      r.index = 4'h5;
      r.pfn   = 20'h00ABC;
      r.c     = 3'd3;
      r.d     = 1'b1;
      r.v     = 1'b1;
    end
    return r;
  endfunction

  always_comb tres = lookup(tif.s_vpn2, tif.s_odd_page,
                            tif.s_asid, gen, ov_en);
  assign tif.s_found = tres.found;
  assign tif.s_index = tres.index;
  assign tif.s_pfn   = tres.pfn;
  assign tif.s_c     = tres.c;
  assign tif.s_d     = tres.d;
  assign tif.s_v     = tres.v;

  always @(posedge clk) if (tlb_write) gen <= gen + 1;

  function automatic void chk(input string nm,
    input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endfunction

  // Scoreboard monitor: predicts each grant from the
  // request lines, queues the expected lookup, and checks
  // every presented response against the TLB contents.
  initial begin : mon
    exp_t       e;
    tres_t      r;
    owner_e     own;
    logic [2:0] act_v, exp_v;
    logic       done;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        chk("reset_quiet", {inst_ack, data_ack,
            inst_rsp_valid, data_rsp_valid,
            probe_done}, 0);
        sb_q.delete();
        mon_busy = 0;
        fav_data = 0;
        wait_cyc = 0;
        wr_seen  = 0;
        continue;
      end
      act_v = {inst_rsp_valid, data_rsp_valid,
               probe_done};
      if (act_v != 0)
        chk("rsp_onehot",
            64'($countones(act_v) > 1), 0);
      if (!mon_busy) begin
        if (act_v != 0) chk("stray_rsp", act_v, 0);
        if (probe_req | inst_req | data_req) begin
          if (probe_req) own = OWN_PROBE;
          else if (inst_req && (!data_req || !fav_data))
            own = OWN_INST;
          else own = OWN_DATA;
          chk("grant_ack", {inst_ack, data_ack},
              {own == OWN_INST, own == OWN_DATA});
          e.own  = own;
          e.asid = cp0_entryhi[7:0];
          if (own == OWN_PROBE) begin
            e.vpn2 = cp0_entryhi[31:13];
            e.odd  = 1'b0;
          end else if (own == OWN_INST) begin
            e.vpn2 = inst_va[31:13];
            e.odd  = inst_va[12];
          end else begin
            e.vpn2 = data_va[31:13];
            e.odd  = data_va[12];
          end
          sb_q.push_back(e);
          mon_busy = 1;
          wait_cyc = 0;
          wr_seen  = 0;
        end else if (inst_ack | data_ack) begin
          chk("idle_ack", {inst_ack, data_ack}, 0);
        end
      end else begin
        wait_cyc++;
        chk("busy_ack", {inst_ack, data_ack}, 0);
        if (!wr_seen && wait_cyc == 2)
          chk("latency", 64'(act_v != 0), 1);
        if (act_v != 0) begin
          e = sb_q[0];
          exp_v = {e.own == OWN_INST, e.own == OWN_DATA,
                   e.own == OWN_PROBE};
          chk("rsp_owner", act_v, exp_v);
          chk("early_rsp", 64'(wait_cyc < 2), 0);
          r = lookup(e.vpn2, e.odd, e.asid, gen, ov_en);
          chk("rsp_data", rsp_vec, r);
          if (e.own == OWN_PROBE) done = probe_done;
          else if (e.own == OWN_INST)
            done = inst_rsp_valid & inst_rsp_ready;
          else done = data_rsp_valid & data_rsp_ready;
          if (done) begin
            void'(sb_q.pop_front());
            mon_busy = 0;
            if (e.own == OWN_INST) fav_data = 1;
            else if (e.own == OWN_DATA) fav_data = 0;
          end
        end
        if (tlb_write) wr_seen = 1;
        if (mon_busy && wait_cyc > 60) begin
          chk("timeout", 1, 0);
          sb_q.delete();
          mon_busy = 0;
        end
      end
    end
  end

  // One clock: sample outputs mid-cycle, then update
  // requests just after the edge (drop on ack/done).
  task automatic cycle();
    @(negedge clk);
    smp_iack = inst_ack;
    smp_dack = data_ack;
    smp_pd   = probe_done;
    smp_iv   = inst_rsp_valid;
    smp_dv   = data_rsp_valid;
    smp_vpn2 = tif.s_vpn2;
    smp_odd  = tif.s_odd_page;
    smp_asid = tif.s_asid;
    smp_rsp  = rsp_vec;
    @(posedge clk);
    #1;
    cyc++;
    if (!hold) begin
      if (smp_iack) inst_req = 1'b0;
      if (smp_dack) data_req = 1'b0;
    end
    if (smp_pd) probe_req = 1'b0;
  endtask

  task automatic do_reset();
    inst_req  = 0;
    data_req  = 0;
    probe_req = 0;
    tlb_write = 0;
    hold      = 0;
    inst_rsp_ready = 1;
    data_rsp_ready = 1;
    resetn = 0;
    cycle();
    cycle();
    resetn = 1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin : stim
    int    who[4];
    int    at[4];
    int    n, g0, pdn, pd_at, ack_at;
    logic  ack_i;
    logic [4:0] pat;
    logic  seen;
    tres_t r;
    #1;

    // Reset values
    do_reset();
    chk("reset_state", {smp_iack, smp_dack, smp_pd,
        smp_iv, smp_dv, smp_vpn2, smp_odd, smp_asid,
        smp_rsp}, 0);

    // Single fetch lookup with fixed TLB entry
    ov_en       = 1;
    cp0_entryhi = 32'h0000_0012;
    inst_va     = 32'h0040_3000;
    inst_req    = 1;
    cycle();
    chk("s1_ack", smp_iack, 1);
    cycle();
    chk("s1_key", {smp_vpn2, smp_odd, smp_asid},
        {19'h00201, 1'b1, 8'h12});
    cycle();
    chk("s1_valid", smp_iv, 1);
    chk("s1_pfn", {smp_rsp[29], smp_rsp[24:5]},
        {1'b1, 20'h00ABC});
    drain(2);
    ov_en = 0;

    // inst/data held together alternate every 3 cycles
    do_reset();
    inst_va  = $urandom;
    data_va  = $urandom;
    inst_req = 1;
    data_req = 1;
    hold     = 1;
    n = 0;
    for (int k = 0; k < 30 && n < 4; k++) begin
      cycle();
      if (smp_iack | smp_dack) begin
        who[n] = int'(smp_dack);
        at[n]  = cyc;
        n++;
      end
    end
    hold = 0;
    inst_req = 0;
    data_req = 0;
    chk("rr_count", n, 4);
    for (int i = 0; i < n; i++)
      chk("rr_order", who[i], i % 2);
    for (int i = 1; i < n; i++)
      chk("ack_gap", at[i] - at[i-1], 3);
    drain(6);

    // Probe wins and does not move rr
    do_reset();
    cp0_entryhi = $urandom;
    inst_va   = $urandom;
    data_va   = $urandom;
    probe_req = 1;
    inst_req  = 1;
    data_req  = 1;
    cycle();
    g0 = cyc;
    chk("probe_first", {smp_iack, smp_dack}, 0);
    pdn = 0;
    pd_at = 0;
    ack_at = 0;
    ack_i = 0;
    for (int k = 0; k < 12 && ack_at == 0; k++) begin
      cycle();
      if (smp_pd) begin
        pdn++;
        pd_at = cyc;
      end
      if (smp_iack | smp_dack) begin
        ack_at = cyc;
        ack_i  = smp_iack;
      end
    end
    chk("probe_pulse", pdn, 1);
    chk("probe_lat", pd_at - g0, 2);
    chk("after_probe", {ack_i, 32'(ack_at - g0)},
        {1'b1, 32'd3});
    drain(8);

    // Write during SEARCH forces one extra lookup
    do_reset();
    cp0_entryhi = $urandom;
    inst_va  = $urandom;
    inst_req = 1;
    cycle();
    chk("s4_ack", smp_iack, 1);
    tlb_write = 1;
    cycle();
    tlb_write = 0;
    cycle();
    chk("s4_no_valid", smp_iv, 0);
    cycle();
    chk("s4_valid", smp_iv, 1);
    r = lookup(inst_va[31:13], inst_va[12],
               cp0_entryhi[7:0], gen, 1'b0);
    chk("s4_new_entry", smp_rsp, r);
    drain(2);

    // Stalled response with a write in the middle
    do_reset();
    cp0_entryhi = $urandom;
    inst_va  = $urandom;
    data_va  = $urandom;
    inst_rsp_ready = 0;
    inst_req = 1;
    cycle();
    chk("s5_ack", smp_iack, 1);
    data_req = 1;
    cycle();
    seen = smp_dack;
    pat  = '0;
    for (int j = 0; j < 5; j++) begin
      tlb_write = (j == 2);
      cycle();
      pat  = {pat[3:0], smp_iv};
      seen = seen | smp_dack;
    end
    tlb_write = 0;
    chk("s5_valid_pat", pat, 5'b11101);
    inst_rsp_ready = 1;
    cycle();
    chk("s5_handshake", smp_iv, 1);
    seen = seen | smp_dack;
    chk("s5_no_other", seen, 0);
    cycle();
    chk("s5_data_next", smp_dack, 1);
    drain(4);

    // Reset while a response is held
    do_reset();
    inst_va = $urandom;
    inst_rsp_ready = 0;
    inst_req = 1;
    cycle();
    cycle();
    cycle();
    chk("s6_in_resp", smp_iv, 1);
    #2;
    resetn = 0;
    #1;
    chk("s6_async_clr", {inst_ack, data_ack,
        inst_rsp_valid, data_rsp_valid, probe_done,
        rsp_vec, tif.s_vpn2, tif.s_odd_page,
        tif.s_asid}, 0);
    cycle();
    cycle();
    resetn = 1;
    inst_rsp_ready = 1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      seen = seen | smp_iv | smp_dv | smp_pd;
    end
    chk("s6_no_stale", seen, 0);

    // Random traffic
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if (!inst_req && $urandom_range(0, 3) == 0)
        inst_req = 1;
      else if (inst_req && $urandom_range(0, 19) == 0)
        inst_req = 0;
      if (!data_req && $urandom_range(0, 3) == 0)
        data_req = 1;
      else if (data_req && $urandom_range(0, 19) == 0)
        data_req = 0;
      if (!probe_req && $urandom_range(0, 15) == 0)
        probe_req = 1;
      inst_va     = $urandom;
      data_va     = $urandom;
      cp0_entryhi = $urandom;
      inst_rsp_ready = 1'($urandom_range(0, 1));
      data_rsp_ready = 1'($urandom_range(0, 1));
      tlb_write = ($urandom_range(0, 9) == 0);
      cycle();
    end
    inst_req  = 0;
    data_req  = 0;
    tlb_write = 0;
    inst_rsp_ready = 1;
    data_rsp_ready = 1;
    // Probe stays raised until done; let it finish.
    drain(20);
    chk("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
